// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer: state encoding,
// ALU function codes and the settle counter width.
package alu_seq_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ENABLE,
        ST_DRIVE,
        ST_LOAD,
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_t;

    // Function codes as seen by the 3-to-8 decoder (bit order is the relay wiring).
    localparam logic [2:0] FCTN_ADD  = 3'b000;
    localparam logic [2:0] FCTN_INC  = 3'b100;
    localparam logic [2:0] FCTN_AND  = 3'b010;
    localparam logic [2:0] FCTN_OR   = 3'b110;
    localparam logic [2:0] FCTN_XOR  = 3'b001;
    localparam logic [2:0] FCTN_NOT  = 3'b101;
    localparam logic [2:0] FCTN_SHL  = 3'b011;
    localparam logic [2:0] FCTN_NULL = 3'b111;

    function automatic logic is_timed(input state_t s);
        return (s == ST_SELECT) || (s == ST_ENABLE) || (s == ST_DRIVE) ||
               (s == ST_HOLD)   || (s == ST_RELEASE);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_settle_timer.sv
// Loadable down-counter used to time relay settling; tc is high once the
// count has reached zero and stays there until the next load.
module settle_timer
    import alu_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Steps one ALU operation through decoder select/enable, bus drive, register
// load and release, with every relay phase held for SETTLE_CYCLES clocks.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] fctn_code,
    input  logic       dest_d,
    output logic [2:0] fctn_sel,
    output logic       dec_enable,
    output logic       alu_drive,
    output logic       load_a,
    output logic       load_d,
    output logic       load_cond,
    output logic       busy,
    output logic       done
);

    // The counter runs S-1 .. 0, so a timed state is left on the edge after tc.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic       dest_sel_q, dest_sel_d;
    logic       tmr_load;
    logic       tmr_tc;

    logic [2:0] fctn_sel_q, fctn_sel_d;
    logic       dec_enable_q, dec_enable_d;
    logic       alu_drive_q, alu_drive_d;
    logic       load_cond_q, load_cond_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] load_vec_q, load_vec_d;

    settle_timer #(.W(CNT_W)) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (RELOAD),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        dest_sel_d = dest_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SELECT;
                    code_d     = fctn_code;
                    dest_sel_d = dest_d;
                end
            end
            ST_SELECT:  if (tmr_tc) state_d = ST_ENABLE;
            ST_ENABLE: begin
                if (tmr_tc) begin
                    state_d = (code_q == FCTN_NULL) ? ST_RELEASE : ST_DRIVE;
                end
            end
            ST_DRIVE:   if (tmr_tc) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_HOLD;
            ST_HOLD:    if (tmr_tc) state_d = ST_RELEASE;
            ST_RELEASE: if (tmr_tc) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        tmr_load = is_timed(state_d) && (state_d != state_q);
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe, without any input-to-output path.
    always_comb begin
        fctn_sel_d   = (state_d == ST_IDLE) ? 3'b000 : code_d;
        dec_enable_d = (state_d == ST_ENABLE) || (state_d == ST_DRIVE) ||
                       (state_d == ST_LOAD)   || (state_d == ST_HOLD);
        alu_drive_d  = (state_d == ST_DRIVE) || (state_d == ST_LOAD) ||
                       (state_d == ST_HOLD);
        load_cond_d  = (state_d == ST_LOAD);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    // Bit 0 strobes register A, bit 1 strobes register D.
    for (genvar gi = 0; gi < 2; gi++) begin : g_load
        assign load_vec_d[gi] = (state_d == ST_LOAD) && (dest_sel_d == 1'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            code_q       <= 3'b000;
            dest_sel_q   <= 1'b0;
            fctn_sel_q   <= 3'b000;
            dec_enable_q <= 1'b0;
            alu_drive_q  <= 1'b0;
            load_cond_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_vec_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            dest_sel_q   <= dest_sel_d;
            fctn_sel_q   <= fctn_sel_d;
            dec_enable_q <= dec_enable_d;
            alu_drive_q  <= alu_drive_d;
            load_cond_q  <= load_cond_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_vec_q   <= load_vec_d;
        end
    end

    assign fctn_sel   = fctn_sel_q;
    assign dec_enable = dec_enable_q;
    assign alu_drive  = alu_drive_q;
    assign load_a     = load_vec_q[0];
    assign load_d     = load_vec_q[1];
    assign load_cond  = load_cond_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (SETTLE_CYCLES 4 and 1) checked
// every cycle against a phase-window model, plus directed literal checks.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       st [2];
    logic [2:0] fc [2];
    logic       dd [2];
    logic       rs [2];

    logic [2:0] o_fs [2];
    logic       o_dec [2], o_alu [2], o_la [2], o_ld [2], o_lc [2], o_busy [2], o_done [2];
    logic [9:0] got [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    alu_op_sequencer dut4 (
        .clk(clk), .reset(rs[0]), .start(st[0]), .fctn_code(fc[0]), .dest_d(dd[0]),
        .fctn_sel(o_fs[0]), .dec_enable(o_dec[0]), .alu_drive(o_alu[0]),
        .load_a(o_la[0]), .load_d(o_ld[0]), .load_cond(o_lc[0]),
        .busy(o_busy[0]), .done(o_done[0])
    );

    alu_op_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(rs[1]), .start(st[1]), .fctn_code(fc[1]), .dest_d(dd[1]),
        .fctn_sel(o_fs[1]), .dec_enable(o_dec[1]), .alu_drive(o_alu[1]),
        .load_a(o_la[1]), .load_d(o_ld[1]), .load_cond(o_lc[1]),
        .busy(o_busy[1]), .done(o_done[1])
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_pack
        assign got[gi] = {o_fs[gi], o_dec[gi], o_alu[gi], o_la[gi], o_ld[gi],
                          o_lc[gi], o_busy[gi], o_done[gi]};
    end

    // ---------------- behavioural model ----------------
    // k = cycles since the accepting edge (0 = idle); outputs follow from
    // which phase window k falls into.
    int         settle [2] = '{4, 1};
    int         m_k [2]    = '{0, 0};
    logic [2:0] m_code [2] = '{3'b000, 3'b000};
    logic       m_dest [2] = '{1'b0, 1'b0};

    function automatic int done_cycle(input int s, input logic [2:0] c);
        return (c == 3'b111) ? 3 * s + 1 : 5 * s + 2;
    endfunction

    function automatic logic [9:0] expect_out(input int s, input logic [2:0] c,
                                              input logic d, input int k);
        logic [2:0] fs;
        logic dec, alu, la, ld, lc, bsy, dn;
        int dk;
        fs = 3'b000; dec = 0; alu = 0; la = 0; ld = 0; lc = 0; bsy = 0; dn = 0;
        dk = done_cycle(s, c);
        if (k >= 1 && k <= dk) begin
            fs  = c;
            bsy = 1'b1;
            dn  = (k == dk);
            if (c == 3'b111) begin
                dec = (k >= s + 1) && (k <= 2 * s);
            end else begin
                dec = (k >= s + 1) && (k <= 4 * s + 1);
                alu = (k >= 2 * s + 1) && (k <= 4 * s + 1);
                if (k == 3 * s + 1) begin
                    la = ~d; ld = d; lc = 1'b1;
                end
            end
        end
        return {fs, dec, alu, la, ld, lc, bsy, dn};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rs[i]) begin
                m_k[i] <= 0;
            end else if (m_k[i] == 0) begin
                if (st[i]) begin
                    m_k[i]    <= 1;
                    m_code[i] <= fc[i];
                    m_dest[i] <= dd[i];
                end
            end else if (m_k[i] == done_cycle(settle[i], m_code[i])) begin
                m_k[i] <= 0;
            end else begin
                m_k[i] <= m_k[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [9:0] e;
                e = expect_out(settle[i], m_code[i], m_dest[i], m_k[i]);
                n_checks++;
                if (got[i] !== e) begin
                    n_errors++;
                    $display("FAIL model dut%0d t=%0t k=%0d got %b exp %b",
                             i, $time, m_k[i], got[i], e);
                end
            end
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic chk(input string name, input int g, input int e);
        n_checks++;
        if (g !== e) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", name, g, e);
        end
    endtask

    task automatic gap();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_add();
        fc[0] = 3'b000; dd[0] = 1'b0; st[0] = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (k == 1) st[0] = 1'b0;
            chk("add_load_d_low", o_ld[0], 0);
            case (k)
                4:  chk("add_dec_c4", o_dec[0], 0);
                5:  chk("add_dec_c5", o_dec[0], 1);
                8:  chk("add_alu_c8", o_alu[0], 0);
                9:  chk("add_alu_c9", o_alu[0], 1);
                13: begin
                    chk("add_load_a_c13", o_la[0], 1);
                    chk("add_load_cond_c13", o_lc[0], 1);
                end
                14: chk("add_load_a_c14", o_la[0], 0);
                21: chk("add_done_c21", o_done[0], 0);
                22: begin
                    chk("add_done_c22", o_done[0], 1);
                    chk("add_busy_c22", o_busy[0], 1);
                end
                23: begin
                    chk("add_busy_c23", o_busy[0], 0);
                    chk("add_done_c23", o_done[0], 0);
                end
                default: ;
            endcase
        end
        $display("txn add: done at cycle 22, busy low at 23");
    endtask

    task automatic test_null();
        fc[0] = 3'b111; dd[0] = 1'b1; st[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) st[0] = 1'b0;
            chk("null_no_strobe", {o_alu[0], o_la[0], o_ld[0], o_lc[0]}, 0);
            if (k == 4 || k == 9) chk("null_dec_off", o_dec[0], 0);
            if (k >= 5 && k <= 8) chk("null_dec_on", o_dec[0], 1);
            if (k == 12) chk("null_done_c12", o_done[0], 0);
            if (k == 13) chk("null_done_c13", o_done[0], 1);
            if (k == 14) chk("null_busy_c14", o_busy[0], 0);
        end
        $display("txn null: done at cycle 13");
    endtask

    task automatic test_xor();
        fc[0] = 3'b001; dd[0] = 1'b0; st[0] = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (k == 1) st[0] = 1'b0;
            if (k == 10) begin fc[0] = 3'b101; st[0] = 1'b1; end
            if (k == 11) st[0] = 1'b0;
            if (k >= 11 && k <= 22) chk("xor_sel_held", o_fs[0], 3'b001);
            if (k == 22) chk("xor_done_c22", o_done[0], 1);
            if (k == 23) chk("xor_idle_c23", o_busy[0], 0);
        end
        $display("txn xor: mid-op start/code change ignored");
    endtask

    task automatic test_reset();
        fc[0] = 3'b100; dd[0] = 1'b1; st[0] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 1) st[0] = 1'b0;
            if (k == 10) rs[0] = 1'b1;
            if (k == 11) begin
                chk("rst_all_zero", got[0], 0);
                rs[0] = 1'b0;
            end
            if (k >= 11) chk("rst_no_done", o_done[0], 0);
        end
        fc[0] = 3'b000; dd[0] = 1'b1; st[0] = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) st[0] = 1'b0;
            if (k == 13) chk("post_rst_load_d", o_ld[0], 1);
            if (k == 22) chk("post_rst_done", o_done[0], 1);
        end
        $display("txn reset: inc aborted at cycle 10, new add completed");
    endtask

    task automatic test_shl();
        fc[1] = 3'b011; dd[1] = 1'b1; st[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) chk("shl_load_d_c3", o_ld[1], 0);
            if (k == 4) chk("shl_load_d_c4", o_ld[1], 1);
            if (k == 7) chk("shl_done_c7", o_done[1], 1);
            if (k == 8) chk("shl_idle_c8", o_busy[1], 0);
            if (k == 9) begin
                chk("shl_reaccept_c9", o_busy[1], 1);
                chk("shl_sel_c9", o_fs[1], 3'b011);
            end
        end
        st[1] = 1'b0;
        repeat (10) @(negedge clk);
        $display("txn shl: settle=1, second acceptance at cycle 8");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; fc[i] = 3'b000; dd[i] = 1'b0; rs[i] = 1'b1;
        end
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs4", got[0], 0);
        chk("reset_outputs1", got[1], 0);
        rs[0] = 1'b0; rs[1] = 1'b0;
        gap();
        test_add();   gap();
        test_null();  gap();
        test_xor();   gap();
        test_reset(); gap();
        test_shl();   gap();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                st[i] = ($urandom_range(0, 3) == 0);
                fc[i] = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom);
                dd[i] = 1'($urandom);
                rs[i] = ($urandom_range(0, 96) == 0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; rs[i] = 1'b0;
        end
        repeat (30) @(negedge clk);
        $display("txn random: 3000 cycles on both instances");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, relay settle time in clocks; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to execute one ALU operation; sampled only in IDLE.
REQ-005 fctn_code  input  3  ALU function code; captured with start.
REQ-006 dest_d  input  1  destination select, captured with start: 0 = register A, 1 = register D.
REQ-007 fctn_sel  output  3  held function code driven to the 3-to-8 function decoder.
REQ-008 dec_enable  output  1  decoder supply (V) enable.
REQ-009 alu_drive  output  1  ALU result onto the data bus.
REQ-010 load_a, load_d  output  1 each  destination register load strobes.
REQ-011 load_cond  output  1  condition register (Z, S, C) load strobe.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle completion pulse.

Function
REQ-014 States: IDLE, SELECT, ENABLE, DRIVE, LOAD, HOLD, RELEASE, DONE.
REQ-015 IDLE with start=1 at a rising edge: capture fctn_code and dest_d; go to SELECT; start is ignored in all other states.
REQ-016 Timed states (SELECT, ENABLE, DRIVE, HOLD, RELEASE) each last exactly SETTLE_CYCLES cycles; LOAD and DONE last exactly 1 cycle.
REQ-017 Normal sequence: SELECT -> ENABLE -> DRIVE -> LOAD -> HOLD -> RELEASE -> DONE -> IDLE.
REQ-018 NULL code (3'b111) sequence: SELECT -> ENABLE -> RELEASE -> DONE -> IDLE; alu_drive, load_a, load_d and load_cond never assert.
REQ-019 fctn_sel equals the captured code in every non-IDLE state and is 0 in IDLE.
REQ-020 dec_enable is 1 in ENABLE, DRIVE, LOAD and HOLD only.
REQ-021 alu_drive is 1 in DRIVE, LOAD and HOLD only.
REQ-022 In LOAD: exactly one of load_a and load_d is 1, selected by captured dest_d; load_cond is 1.
REQ-023 done is 1 only in DONE.
REQ-024 All outputs are registered, with no combinational path from inputs to outputs.
REQ-025 Latency, normal op: done is high in cycle 5*SETTLE_CYCLES+2 after the accepting edge (22 for the default).
REQ-026 Latency, NULL op: done is high in cycle 3*SETTLE_CYCLES+1 after the accepting edge (13 for the default).
REQ-027 start held high through DONE does not start a new operation in DONE; it is accepted at the first IDLE cycle, so there is a minimum of one IDLE cycle between operations.
REQ-028 Changes on fctn_code or dest_d after acceptance have no effect until the next acceptance.

Reset
REQ-029 reset=1 at a rising edge forces IDLE and clears the settle counter, captured code and captured dest_d, in any state.
REQ-030 After that edge, all outputs (fctn_sel, dec_enable, alu_drive, load_a, load_d, load_cond, busy, done) are 0.
REQ-031 Reset takes priority over start; no done is produced for an operation aborted by reset.

Structure
REQ-032 Shared package alu_seq_pkg holds:
- the state enum;
- function code constants ADD=000, INC=100, AND=010, OR=110, XOR=001, NOT=101, SHL=011, NULL=111;
- the settle counter width (8).
REQ-033 One sub-module, settle_timer:
- loadable down-counter with a terminal-count flag;
- reloaded on every timed-state entry;
- instantiated once.

Verification
REQ-034 ADD (000), dest_d=0, default SETTLE_CYCLES:
- dec_enable rises at cycle 5;
- alu_drive rises at cycle 9;
- load_a and load_cond pulse at cycle 13;
- load_d stays 0;
- done pulses at cycle 22;
- busy falls at cycle 23.
REQ-035 NULL (111), dest_d=1: dec_enable high cycles 5..8; alu_drive, load_a, load_d and load_cond stay 0; done pulses at cycle 13.
REQ-036 During an XOR op, change fctn_code to 101 and pulse start at cycle 10: fctn_sel stays 001 and the operation is not restarted.
REQ-037 Reset asserted at cycle 10 of an INC op: the next cycle has all outputs 0, state IDLE and no done; a new start is then accepted normally.
REQ-038 SETTLE_CYCLES=1, SHL (011), dest_d=1: load_d pulses at cycle 4 and done at cycle 7; start held high continuously gives the second acceptance at cycle 8.
